// File: rtl/instr_encoder_pkg.sv
// Shared RV32I opcode constants, instruction-format codes and the S1 opcode classifier.
package instr_encoder_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP        = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_SH = 3'd6
  } fmt_t;

  // Unknown opcodes fall back to I-type packing; the caller flags them separately.
  function automatic fmt_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
    fmt_t f;
    case (opcode)
      OP_LUI, OP_AUIPC:          f = FMT_U;
      OP_JAL:                    f = FMT_J;
      OP_BRANCH:                 f = FMT_B;
      OP_STORE:                  f = FMT_S;
      OP:                        f = FMT_R;
      OP_IMM:                    f = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
      default:                   f = FMT_I;
    endcase
    return f;
  endfunction

  function automatic logic known_opcode(input logic [6:0] opcode);
    return opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                          OP_LOAD, OP_STORE, OP_IMM, OP};
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational packer from classified fields to a 32-bit RV32I word
// plus an "immediate not representable / opcode unknown" flag.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  fmt_t        fmt,
  input  logic        bad_op,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic same_31_11, same_31_12, same_31_20;

  // An immediate fits when every bit above its top field bit equals the sign bit.
  assign same_31_11 = (&imm[31:11]) || !(|imm[31:11]);
  assign same_31_12 = (&imm[31:12]) || !(|imm[31:12]);
  assign same_31_20 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    instr = '0;
    err   = 1'b0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_SH: begin
        instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        err   = |imm[31:5];
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !same_31_11;
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = !same_31_12 || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = |imm[11:0];
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = !same_31_20 || imm[0];
      end
      default: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !same_31_11;
      end
    endcase
    if (bad_op)
      err = 1'b1;
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage streaming RV32I encoder with valid/ready on both sides and a byte-address tag.
// Optional ENC_STATS_EN adds saturating word/error counters on the output handshake.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
`ifdef ENC_STATS_EN
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_errs,
`endif
  output logic              out_err
);

  logic              s1_valid_reg;
  fmt_t              s1_fmt_reg;
  logic              s1_badop_reg;
  logic [6:0]        s1_opcode_reg;
  logic [4:0]        s1_rd_reg, s1_rs1_reg, s1_rs2_reg;
  logic [2:0]        s1_funct3_reg;
  logic [6:0]        s1_funct7_reg;
  logic [31:0]       s1_imm_reg;

  logic              s2_valid_reg;
  logic [31:0]       out_instr_reg;
  logic              out_err_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic              s2_ready;
  logic              out_fire;
  logic [31:0]       pack_instr;
  logic              pack_err;

  assign s2_ready  = !s2_valid_reg || out_ready;
  assign in_ready  = !s1_valid_reg || s2_ready;
  assign out_fire  = s2_valid_reg && out_ready;

  assign out_valid = s2_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_err   = out_err_reg;
  assign out_addr  = addr_reg;

  instr_pack u_pack (
    .fmt    (s1_fmt_reg),
    .bad_op (s1_badop_reg),
    .opcode (s1_opcode_reg),
    .rd     (s1_rd_reg),
    .rs1    (s1_rs1_reg),
    .rs2    (s1_rs2_reg),
    .funct3 (s1_funct3_reg),
    .funct7 (s1_funct7_reg),
    .imm    (s1_imm_reg),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  // S1 datapath fields are qualified by s1_valid_reg, so they carry no reset.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_fmt_reg    <= classify(in_opcode, in_funct3);
      s1_badop_reg  <= !known_opcode(in_opcode);
      s1_opcode_reg <= in_opcode;
      s1_rd_reg     <= in_rd;
      s1_rs1_reg    <= in_rs1;
      s1_rs2_reg    <= in_rs2;
      s1_funct3_reg <= in_funct3;
      s1_funct7_reg <= in_funct7;
      s1_imm_reg    <= in_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_instr_reg <= '0;
      out_err_reg   <= 1'b0;
      addr_reg      <= ADDR_W'(RESET_ADDR);
    end else begin
      if (in_ready)
        s1_valid_reg <= in_valid;
      if (s2_ready) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_instr_reg <= pack_instr;
          out_err_reg   <= pack_err;
        end
      end
      // A load wins over the increment; the word leaving this cycle keeps the old address.
      if (addr_load)
        addr_reg <= addr_base;
      else if (out_fire)
        addr_reg <= addr_reg + ADDR_W'(4);
    end
  end

`ifdef ENC_STATS_EN
  logic [15:0] stat_words_reg, stat_errs_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_reg <= '0;
      stat_errs_reg  <= '0;
    end else if (out_fire) begin
      if (stat_words_reg != 16'hFFFF)
        stat_words_reg <= stat_words_reg + 16'd1;
      if (out_err_reg && stat_errs_reg != 16'hFFFF)
        stat_errs_reg <= stat_errs_reg + 16'd1;
    end
  end

  assign stat_words = stat_words_reg;
  assign stat_errs  = stat_errs_reg;
`endif

endmodule
